// File: rtl/text_source.sv
// Streams a stored text frame out of a synchronous memory: filler preamble, then payload bytes.
// Optional trailing checksum byte when TEXT_SOURCE_CHECKSUM_EN is defined.
module text_source #(
  parameter int          DATA_W        = 8,
  parameter int          ADDR_W        = 8,
  parameter int          END_ADDRESS   = 15,
  parameter int          PREAMBLE_LEN  = 2,
  parameter logic [7:0]  PREAMBLE_BYTE = 8'hAA
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_source,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_q,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              busy,
  output logic              done
);

  // state | meaning
  // IDLE  | waiting for start_source, address parked at 0
  // PRE   | presenting filler bytes until PREAMBLE_LEN have been accepted
  // WAIT1 | memory registers mem_address
  // WAIT2 | memory data available, captured into data_out
  // SEND  | presenting a payload byte
  // CSUM  | presenting the checksum byte (optional)
  // DONE  | frame finished, pulse done on the way back to IDLE
`ifdef TEXT_SOURCE_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_WAIT1, S_WAIT2, S_SEND, S_CSUM, S_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_WAIT1, S_WAIT2, S_SEND, S_DONE
  } state_t;
`endif

  localparam logic [ADDR_W-1:0] END_A    = ADDR_W'(END_ADDRESS);
  localparam logic [3:0]        PRE_LAST = (PREAMBLE_LEN == 0) ? 4'd0 : 4'(PREAMBLE_LEN - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                xfer;

`ifdef TEXT_SOURCE_CHECKSUM_EN
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic [DATA_W-1:0]   sum_nx;
  assign sum_nx = sum_q + dout_q;
`endif

  assign xfer = valid_q & data_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
`ifdef TEXT_SOURCE_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      S_IDLE: begin
        addr_d = '0;
        if (start_source) begin
          busy_d = 1'b1;
          cnt_d  = 4'd0;
`ifdef TEXT_SOURCE_CHECKSUM_EN
          sum_d  = '0;
`endif
          if (PREAMBLE_LEN == 0) begin
            state_d = S_WAIT1;
          end else begin
            state_d = S_PRE;
            dout_d  = DATA_W'(PREAMBLE_BYTE);
            valid_d = 1'b1;
          end
        end
      end
      S_PRE: begin
        if (xfer) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == PRE_LAST) begin
            valid_d = 1'b0;
            state_d = S_WAIT1;
          end
        end
      end
      S_WAIT1: state_d = S_WAIT2;
      S_WAIT2: begin
        dout_d  = mem_q;
        valid_d = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (xfer) begin
          valid_d = 1'b0;
`ifdef TEXT_SOURCE_CHECKSUM_EN
          sum_d   = sum_nx;
`endif
          if (addr_q == END_A) begin
`ifdef TEXT_SOURCE_CHECKSUM_EN
            // checksum byte goes out immediately, no memory wait
            dout_d  = -sum_nx;
            valid_d = 1'b1;
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_WAIT1;
          end
        end
      end
`ifdef TEXT_SOURCE_CHECKSUM_EN
      S_CSUM: begin
        if (xfer) begin
          valid_d = 1'b0;
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        addr_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= 4'd0;
`ifdef TEXT_SOURCE_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
`ifdef TEXT_SOURCE_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign mem_address = addr_q;
  assign data_out    = dout_q;
  assign data_valid  = valid_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: doc/text_source.md
Name: text_source

Overview:
- Transmit-side counterpart of the text sink.
- Reads a stored text frame from a synchronous single-port memory (registered address, 1-cycle read latency) and emits it byte by byte over a valid/ready stream toward the channel encoder.
- Each frame is prefixed with PREAMBLE_LEN filler bytes. The receiving sink discards its first two bytes, so the default is 2.

Parameters:
- DATA_W, 8: byte width of memory data and stream.
- ADDR_W, 8: memory address width.
- END_ADDRESS, 15: last memory address transmitted. Payload is addresses 0..END_ADDRESS inclusive.
- PREAMBLE_LEN, 2: number of filler bytes sent before the payload. Legal range 0..15.
- PREAMBLE_BYTE, 8'hAA: value of each filler byte.

Ports:
- clk, input, 1: clock.
- reset, input, 1: asynchronous, active-high reset.
- start_source, input, 1: level; sampled only in IDLE; starts one frame.
- mem_address, output, ADDR_W: registered read address to the memory.
- mem_q, input, DATA_W: memory read data, valid 2 edges after mem_address changes.
- data_out, output, DATA_W: stream byte.
- data_valid, output, 1: data_out holds a byte.
- data_ready, input, 1: downstream accepts the byte. Transfer occurs at a posedge where data_valid && data_ready.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset (async) values: state=IDLE, mem_address=0, data_out=0, data_valid=0, busy=0, done=0, preamble counter=0. Reset mid-frame aborts immediately; no further bytes are sent until a new start.
- All outputs are registered.
- States: IDLE, PRE, WAIT1, WAIT2, SEND, (CSUM), DONE.
- IDLE:
  - mem_address=0.
  - If start_source=1, go to PRE, or to WAIT1 if PREAMBLE_LEN=0. Set busy=1.
- PRE:
  - data_out=PREAMBLE_BYTE, data_valid=1.
  - On each transfer, increment the counter.
  - After the PREAMBLE_LEN-th transfer: data_valid<=0, go to WAIT1.
- WAIT1: memory samples mem_address.
- WAIT2: data_out<=mem_q, data_valid<=1, go to SEND.
- SEND, on transfer:
  - If mem_address==END_ADDRESS: data_valid<=0, go to DONE (or CSUM).
  - Else: mem_address<=mem_address+1, data_valid<=0, go to WAIT1.
- DONE: done=1 for exactly one cycle, busy<=0, mem_address<=0, go to IDLE.
- Latency:
  - First preamble byte is valid on the edge after start_source is sampled.
  - After any transfer that leads to a memory byte, data_valid is low for exactly 2 cycles before the next byte is valid.
- Backpressure: while data_valid=1 and data_ready=0, data_out and data_valid hold stable. data_valid never drops without a transfer.
- start_source is ignored while busy. A start held high through DONE launches a new frame on the cycle after done.
- mem_address never exceeds END_ADDRESS; no wrap-around within a frame.
- Total bytes per frame = PREAMBLE_LEN + END_ADDRESS + 1.

Optional Feature:
- Macro: TEXT_SOURCE_CHECKSUM_EN.
- When defined:
  - After the last payload transfer, go to CSUM instead of DONE.
  - CSUM emits one extra byte: the two's-complement of the mod-256 sum of all payload bytes. Preamble bytes are excluded.
  - The checksum byte is valid on the edge after the last payload transfer and obeys the same hold rules.
  - Its transfer leads to DONE.
  - The running sum register resets to 0 on reset and at start.
- When undefined: no CSUM state and no sum register; frame length is as above.

Test Plan:
- Memory preloaded with "HELLO WORLD 0123" (16 bytes), data_ready=1, pulse start_source -> stream AA, AA, 48, 45, 4C, 4C, 4F, ..., 33. Each memory byte is preceded by 2 invalid cycles. done pulses once; busy falls with done.
- Same memory, data_ready toggling 1 0 0 1 pseudo-randomly -> identical byte sequence; data_out stable during every stall; no duplicated or dropped bytes.
- Reset asserted while in SEND at mem_address=7 -> outputs immediately 0, state IDLE. A next start resends the full frame from the preamble and address 0.
- start_source held high for the whole frame -> exactly one frame per start, back-to-back. Second frame's first AA is valid the cycle after done.
- END_ADDRESS=0, PREAMBLE_LEN=0, mem[0]=8'h5A -> single byte 5A, then done; mem_address stays 0.
- TEXT_SOURCE_CHECKSUM_EN defined, payload bytes 01 02 03 ... 10 (sum 0x88) -> extra trailing byte 0x78 before done.
